// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : firebird7_in_gate1_tessent_tdr_pkg
// Purpose  : Shared types and constants for the gate1 data-mux control TDR.
//            Provides the operation decode enum, the TDR length helper and
//            the bit positions of the select bit and the data field.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package firebird7_in_gate1_tessent_tdr_pkg;

  // Scan/update register layout: bit 0 is the mux select, bits above it are
  // the data field.
  localparam int SEL_BIT  = 0;
  localparam int DATA_LSB = 1;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_CAPTURE = 2'd1,
    OP_SHIFT   = 2'd2,
    OP_UPDATE  = 2'd3
  } tdr_op_e;

  // Total TDR length: one select bit plus the data field.
  function automatic int tdr_len(input int data_width);
    return data_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_tdr_data_mux_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : firebird7_in_gate1_tessent_tdr_data_mux_ctl_if
// Purpose  : IJTAG access port plus the data-mux side signals of the TDR.
// Ports    : master - drives sel/ce/se/ue/si and capture_data_in,
//                     observes ijtag_so, ijtag_select, ijtag_data_out
//            slave  - the TDR itself (opposite directions)
// Revision : 1.0 - initial release
// ============================================================================
interface firebird7_in_gate1_tessent_tdr_data_mux_ctl_if #(
  parameter int DATA_WIDTH = 3
);
  logic                  ijtag_sel;
  logic                  ijtag_ce;
  logic                  ijtag_se;
  logic                  ijtag_ue;
  logic                  ijtag_si;
  logic                  ijtag_so;
  logic [DATA_WIDTH-1:0] capture_data_in;
  logic                  ijtag_select;
  logic [DATA_WIDTH-1:0] ijtag_data_out;

  modport master (
    output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, capture_data_in,
    input  ijtag_so, ijtag_select, ijtag_data_out
  );

  modport slave (
    input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, capture_data_in,
    output ijtag_so, ijtag_select, ijtag_data_out
  );
endinterface
`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_tdr_update_reg.sv
`default_nettype none
// ============================================================================
// Module   : firebird7_in_gate1_tessent_tdr_update_reg
// Purpose  : Load-enable register with asynchronous active-high reset to a
//            parameterised value. Holds the TDR update (shadow) contents.
// Ports    : clk    - clock (rising edge)
//            rst    - asynchronous active-high reset
//            load_i - load d_i on the next rising edge
//            d_i    - data to load
//            q_o    - registered contents
// Revision : 1.0 - initial release
// ============================================================================
module firebird7_in_gate1_tessent_tdr_update_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_tdr_data_mux_ctl.sv
`default_nettype none
// ============================================================================
// Module   : firebird7_in_gate1_tessent_tdr_data_mux_ctl
// Purpose  : IJTAG TDR feeding the gate1 instrument data mux. A scan register
//            is shifted/captured on the IJTAG path; an update register drives
//            the mux select and IJTAG data inputs. The mux output is captured
//            back into the scan register for observation.
// Ports    : ijtag_tck   - IJTAG test clock (sole clock, rising edge)
//            ijtag_reset - asynchronous active-high reset
//            bus         - slave side of the TDR interface (sel/ce/se/ue/si,
//                          so, capture_data_in, ijtag_select, ijtag_data_out)
// Revision : 1.0 - initial release
// ============================================================================
module firebird7_in_gate1_tessent_tdr_data_mux_ctl
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 3,
  parameter logic                  RESET_SELECT = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA   = '0
) (
  input wire logic ijtag_tck,
  input wire logic ijtag_reset,
  firebird7_in_gate1_tessent_tdr_data_mux_ctl_if.slave bus
);

  localparam int                C_LEN       = tdr_len(DATA_WIDTH);
  localparam logic [C_LEN-1:0] C_RESET_VAL = {RESET_DATA, RESET_SELECT};

  tdr_op_e            tdr_op;
  logic [C_LEN-1:0]   sr_q;
  logic [C_LEN-1:0]   sr_d;
  logic [C_LEN-1:0]   upd_q;

  // Enable decode. Shift dominates capture, capture dominates update, and a
  // deselected TDR ignores every enable.
  always_comb begin
    tdr_op = OP_IDLE;
    if (bus.ijtag_sel) begin
      if (bus.ijtag_se) begin
        tdr_op = OP_SHIFT;
      end else if (bus.ijtag_ce) begin
        tdr_op = OP_CAPTURE;
      end else if (bus.ijtag_ue) begin
        tdr_op = OP_UPDATE;
      end
    end
  end

  // Scan register next state. Shifting is LSB-first toward ijtag_so with si
  // entering at the MSB; capture records the mux output alongside the select
  // currently applied, so the observed data can be attributed to a path.
  always_comb begin
    sr_d = sr_q;
    case (tdr_op)
      OP_SHIFT:   sr_d = {bus.ijtag_si, sr_q[C_LEN-1:DATA_LSB]};
      OP_CAPTURE: sr_d = {bus.capture_data_in, upd_q[SEL_BIT]};
      default:    sr_d = sr_q;
    endcase
  end

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      sr_q <= C_RESET_VAL;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Only the update register reaches the mux, so shift activity never
  // disturbs the functional path.
  firebird7_in_gate1_tessent_tdr_update_reg #(
    .WIDTH     (C_LEN),
    .RESET_VAL (C_RESET_VAL)
  ) u_upd (
    .clk    (ijtag_tck),
    .rst    (ijtag_reset),
    .load_i (tdr_op == OP_UPDATE),
    .d_i    (sr_q),
    .q_o    (upd_q)
  );

  assign bus.ijtag_so       = sr_q[SEL_BIT];
  assign bus.ijtag_select   = upd_q[SEL_BIT];
  assign bus.ijtag_data_out = upd_q[C_LEN-1:DATA_LSB];

endmodule
`default_nettype wire

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_mux_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_firebird7_in_gate1_tessent_tdr_data_mux_ctl
// Purpose  : Self-checking bench for the gate1 data-mux control TDR. Directed
//            scenarios followed by random IJTAG traffic, all compared against
//            an integer model of the scan and update registers.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_firebird7_in_gate1_tessent_tdr_data_mux_ctl;

  localparam int DW   = 3;
  localparam int LEN  = DW + 1;
  localparam int MASK = (1 << LEN) - 1;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  // Model state: the scan and update registers as plain integers, bit 0 is
  // the select bit, bits LEN-1..1 the data field.
  int   m_sr;
  int   m_upd;

  firebird7_in_gate1_tessent_tdr_data_mux_ctl_if #(.DATA_WIDTH(DW)) bus ();

  firebird7_in_gate1_tessent_tdr_data_mux_ctl #(
    .DATA_WIDTH   (DW),
    .RESET_SELECT (1'b0),
    .RESET_DATA   ('0)
  ) dut (
    .ijtag_tck   (clk),
    .ijtag_reset (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    cmp({tag, ".select"}, {2'b00, bus.ijtag_select}, 3'(m_upd & 1));
    cmp({tag, ".data"},   bus.ijtag_data_out,        3'((m_upd >> 1) & 7));
    cmp({tag, ".so"},     {2'b00, bus.ijtag_so},     3'(m_sr & 1));
  endtask

  task automatic model_reset();
    m_sr  = 0;
    m_upd = 0;
  endtask

  // One ijtag_tck cycle: drive after the falling edge, sample 1 time unit
  // after the rising edge.
  task automatic step(input string tag, input bit sel, input bit ce, input bit se,
                      input bit ue, input bit si, input logic [DW-1:0] cap);
    @(negedge clk);
    bus.ijtag_sel       = sel;
    bus.ijtag_ce        = ce;
    bus.ijtag_se        = se;
    bus.ijtag_ue        = ue;
    bus.ijtag_si        = si;
    bus.capture_data_in = cap;
    @(posedge clk);
    if (sel && se)      m_sr  = ((m_sr >> 1) | (int'(si) << (LEN - 1))) & MASK;
    else if (sel && ce) m_sr  = ((int'(cap) << 1) | (m_upd & 1)) & MASK;
    else if (sel && ue) m_upd = m_sr;
    #1;
    check(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b0;
    bus.ijtag_sel = 1'b0; bus.ijtag_ce = 1'b0; bus.ijtag_se = 1'b0;
    bus.ijtag_ue  = 1'b0; bus.ijtag_si = 1'b0; bus.capture_data_in = '0;

    // Reset asserted between edges must take effect with no clock edge.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_async");
    #3;
    rst = 1'b0;

    // Shift 1,1,0,1 LSB first, then update: select=1, data=3'b101.
    step("shift0", 1, 0, 1, 0, 1, 3'b000);
    step("shift1", 1, 0, 1, 0, 1, 3'b000);
    step("shift2", 1, 0, 1, 0, 0, 3'b000);
    step("shift3", 1, 0, 1, 0, 1, 3'b000);
    step("update", 1, 0, 0, 1, 0, 3'b000);
    cmp("load_select", {2'b00, bus.ijtag_select}, 3'b001);
    cmp("load_data",   bus.ijtag_data_out,        3'b101);

    // Capture mux data 3'b110 with select=1; so shows 1,0,1,1.
    step("capture", 1, 1, 0, 0, 0, 3'b110);
    cmp("cap_so0", {2'b00, bus.ijtag_so}, 3'b001);
    step("cshift0", 1, 0, 1, 0, 0, 3'b110);
    cmp("cap_so1", {2'b00, bus.ijtag_so}, 3'b000);
    step("cshift1", 1, 0, 1, 0, 0, 3'b110);
    cmp("cap_so2", {2'b00, bus.ijtag_so}, 3'b001);
    step("cshift2", 1, 0, 1, 0, 0, 3'b110);
    cmp("cap_so3", {2'b00, bus.ijtag_so}, 3'b001);
    step("cshift3", 1, 0, 1, 0, 0, 3'b110);
    cmp("cap_data_held", bus.ijtag_data_out, 3'b101);

    // Simultaneous enables: shift wins, then capture wins over update.
    step("prio_sh", 1, 1, 1, 1, 1, 3'b011);
    step("prio_ca", 1, 1, 0, 1, 0, 3'b011);
    cmp("prio_data_held", bus.ijtag_data_out, 3'b101);
    step("prio_up", 1, 0, 0, 1, 0, 3'b011);

    // Deselected: every enable ignored.
    for (int i = 0; i < 10; i++) begin
      step("desel", 0, 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 3'($urandom));
    end

    // Reset in the middle of a shift, then a full reload.
    step("mid_sh0", 1, 0, 1, 0, 1, 3'b000);
    step("mid_sh1", 1, 0, 1, 0, 0, 3'b000);
    async_reset("mid_reset");
    step("rl_sh0", 1, 0, 1, 0, 0, 3'b000);
    step("rl_sh1", 1, 0, 1, 0, 1, 3'b000);
    step("rl_sh2", 1, 0, 1, 0, 1, 3'b000);
    step("rl_sh3", 1, 0, 1, 0, 0, 3'b000);
    step("rl_upd", 1, 0, 0, 1, 0, 3'b000);
    cmp("reload_select", {2'b00, bus.ijtag_select}, 3'b000);
    cmp("reload_data",   bus.ijtag_data_out,        3'b011);

    // Random traffic with sparse enables.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom));
      if (i == 150) async_reset("rand_reset");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
